mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, data width of each requester and of the output bus.
REQ-002 Parameter: BURST_LEN, 4, maximum consecutive transfers per grant; used only when MUX2_ARB_BURST_EN is defined; legal range 1..15.
REQ-003 Port: clk  input  1  single clock, rising-edge active.
REQ-004 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-005 Port: req_a  input  1  requester A wants the bus.
REQ-006 Port: a  input  WIDTH  requester A data.
REQ-007 Port: req_b  input  1  requester B wants the bus.
REQ-008 Port: b  input  WIDTH  requester B data.
REQ-009 Port: y_ready  input  1  sink accepts y this cycle.
REQ-010 Port: gnt_a  output  1  A owns the bus.
REQ-011 Port: gnt_b  output  1  B owns the bus.
REQ-012 Port: sel  output  1  mux select; 1 = a, 0 = b.
REQ-013 Port: y  output  WIDTH  shared output bus.
REQ-014 Port: y_valid  output  1  y holds valid data.
REQ-015 Port: xfer_cnt  output  8  count of completed transfers.

Function
REQ-016 The FSM SHALL have three states: IDLE, GNT_A and GNT_B; gnt_a = (state==GNT_A), gnt_b = (state==GNT_B), and sel = gnt_a.
REQ-017 y SHALL be combinational: a in GNT_A, b in GNT_B, and 0 in IDLE.
REQ-018 y_valid SHALL be (gnt_a & req_a) | (gnt_b & req_b), combinational.
REQ-019 A transfer SHALL occur on any cycle with y_valid & y_ready.
REQ-020 xfer_cnt SHALL increment by 1 per transfer and wrap from 255 to 0.
REQ-021 A one-bit register last SHALL record the most recently granted requester; it resets to B, so A wins the first tie.
REQ-022 In IDLE, the FSM SHALL move at the next edge as follows: both requests -> grant the requester other than last; one request -> grant that requester; no request -> stay in IDLE.
REQ-023 Grant latency SHALL be exactly 1 cycle: a request seen in IDLE at edge N produces gnt at N+1.
REQ-024 In GNT_X, on a transfer, the FSM SHALL move to GNT_other if the other requester is requesting, stay in GNT_X if only req_X is high, and go to IDLE if neither is requesting.
REQ-025 In GNT_X with no transfer, the FSM SHALL hold while req_X is high; if req_X drops (withdrawal), it SHALL go to IDLE at the next edge, with y_valid = 0 immediately.
REQ-026 Grant changes SHALL occur only at clock edges; gnt_a and gnt_b are never both 1.
REQ-027 last SHALL update whenever the FSM enters GNT_A or GNT_B.

Reset
REQ-028 While rst_n is low, the block SHALL force: state = IDLE, last = B, xfer_cnt = 0, gnt_a = gnt_b = sel = y_valid = 0, y = 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer; that transfer is not counted.
REQ-030 After rst_n deasserts, the first grant SHALL follow REQ-022.

Configuration
REQ-031 With macro MUX2_ARB_BURST_EN defined, a 4-bit burst counter SHALL count transfers in the current grant; the FSM switches to the other requester only when burst count reaches BURST_LEN or req_X drops; otherwise GNT_X is held despite competing requests.
REQ-032 The burst counter SHALL clear on every grant entry and on reset.
REQ-033 Without MUX2_ARB_BURST_EN, the burst counter SHALL be absent and the block SHALL behave exactly per REQ-024.

Verification
REQ-034 Reset release, req_a=1 and req_b=1 in the same cycle, y_ready=1 -> gnt_a next cycle, then grants alternate A,B,A,B per transfer; xfer_cnt 1,2,3,4.
REQ-035 req_b=1 only, b=4'hC, y_ready=0 for 3 cycles then 1 -> gnt_b and y=4'hC held with y_valid=1 for 4 cycles; xfer_cnt goes 0->1 only on the last cycle.
REQ-036 GNT_A, req_a drops with y_ready=0 -> y_valid=0 the same cycle, state IDLE next edge, xfer_cnt unchanged.
REQ-037 Continuous transfers for 256 cycles -> xfer_cnt wraps to 0.
REQ-038 rst_n pulsed low during an active GNT_B transfer -> all outputs 0 immediately; after release with both requests, A is granted first.
REQ-039 With MUX2_ARB_BURST_EN, BURST_LEN=4, both requests held, y_ready=1 -> 4 transfers from A, then 4 from B, repeating.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Two-requester bus arbiter with round-robin tie-break and a wrapping transfer counter.
// Optional burst mode (define MUX2_ARB_BURST_EN) keeps a grant for up to BURST_LEN transfers.
`timescale 1ns/1ps
module mux2_arbiter #(
  parameter int WIDTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  input  logic             y_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;   // 1 = A was granted last, 0 = B
  logic [7:0] cnt_q, cnt_d;
  logic       xfer;

`ifdef MUX2_ARB_BURST_EN
  localparam logic [3:0] BURST_LIM = 4'(BURST_LEN);
  logic [3:0] burst_q, burst_d, burst_inc;
  logic       burst_done;
  assign burst_inc  = burst_q + 4'd1;
  assign burst_done = (burst_inc == BURST_LIM);
`endif

  assign gnt_a    = (state_q == GNT_A);
  assign gnt_b    = (state_q == GNT_B);
  assign sel      = gnt_a;
  assign y_valid  = (gnt_a & req_a) | (gnt_b & req_b);
  assign xfer     = y_valid & y_ready;
  assign xfer_cnt = cnt_q;

  always_comb begin
    y = '0;
    case (state_q)
      GNT_A:   y = a;
      GNT_B:   y = b;
      default: y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
`ifdef MUX2_ARB_BURST_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_a && req_b) state_d = last_q ? GNT_B : GNT_A;
        else if (req_a)     state_d = GNT_A;
        else if (req_b)     state_d = GNT_B;
      end
      GNT_A: begin
        if (xfer) begin
`ifdef MUX2_ARB_BURST_EN
          burst_d = burst_inc;
          if (!req_a)                    state_d = req_b ? GNT_B : IDLE;
          else if (burst_done && req_b)  state_d = GNT_B;
          else if (burst_done)           burst_d = '0;
`else
          if (req_b)      state_d = GNT_B;
          else if (!req_a) state_d = IDLE;
`endif
        end else if (!req_a) begin
          state_d = IDLE;
        end
      end
      GNT_B: begin
        if (xfer) begin
`ifdef MUX2_ARB_BURST_EN
          burst_d = burst_inc;
          if (!req_b)                    state_d = req_a ? GNT_A : IDLE;
          else if (burst_done && req_a)  state_d = GNT_A;
          else if (burst_done)           burst_d = '0;
`else
          if (req_a)      state_d = GNT_A;
          else if (!req_b) state_d = IDLE;
`endif
        end else if (!req_b) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MUX2_ARB_BURST_EN
    // A fresh grant always starts a fresh burst
    if (state_d != state_q && state_d != IDLE) burst_d = '0;
`endif
  end

  always_comb begin
    last_d = last_q;
    if (state_d == GNT_A)      last_d = 1'b1;
    else if (state_d == GNT_B) last_d = 1'b0;
    cnt_d = cnt_q + {7'd0, xfer};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MUX2_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_q <= '0;
    else        burst_q <= burst_d;
  end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: vector table for arbitration/handshake plus
// hand-written sequences for counter wrap, mid-transfer reset and burst mode.
`timescale 1ns/1ps
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, y_ready;
  logic [3:0] a, b;
  logic       gnt_a, gnt_b, sel, y_valid;
  logic [3:0] y;
  logic [7:0] xfer_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       req_a;
    logic [3:0] a;
    logic       req_b;
    logic [3:0] b;
    logic       y_ready;
    logic       e_gnt_a;
    logic       e_gnt_b;
    logic [3:0] e_y;
    logic       e_valid;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  mux2_arbiter #(.WIDTH(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .a(a), .req_b(req_b), .b(b), .y_ready(y_ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .y(y), .y_valid(y_valid),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ra, input logic [3:0] av, input logic rb,
                               input logic [3:0] bv, input logic rdy);
    req_a   = ra;
    a       = av;
    req_b   = rb;
    b       = bv;
    y_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 8'd0};
    vecs[2]  = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 4'h5, 1'b1, 8'd1};
    vecs[3]  = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 8'd2};
    vecs[4]  = '{1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 4'h5, 1'b1, 8'd3};
    vecs[5]  = '{1'b0, 4'h3, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 8'd4};
    vecs[6]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd4};
    vecs[7]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 8'd4};
    vecs[8]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 8'd4};
    vecs[9]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 8'd4};
    vecs[10] = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 8'd4};
    vecs[11] = '{1'b1, 4'h9, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 8'd5};
    vecs[12] = '{1'b1, 4'h9, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 4'h9, 1'b1, 8'd6};
    vecs[13] = '{1'b0, 4'h9, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 8'd6};
    vecs[14] = '{1'b1, 4'h9, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd6};
    vecs[15] = '{1'b1, 4'h9, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 8'd6};
    vecs[16] = '{1'b0, 4'h9, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 8'd6};
    vecs[17] = '{1'b0, 4'h9, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd6};

    // Outputs must be forced low while reset is held, even with live requests
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'hA, 1'b1, 4'h6, 1'b1);
    #1;
    checkOutput("rst gnt_a",   32'(gnt_a),    32'd0);
    checkOutput("rst gnt_b",   32'(gnt_b),    32'd0);
    checkOutput("rst sel",     32'(sel),      32'd0);
    checkOutput("rst y",       32'(y),        32'd0);
    checkOutput("rst y_valid", 32'(y_valid),  32'd0);
    checkOutput("rst cnt",     32'(xfer_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

`ifndef MUX2_ARB_BURST_EN
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].req_a, vecs[i].a, vecs[i].req_b, vecs[i].b, vecs[i].y_ready);
      #1;
      checkOutput($sformatf("v%0d gnt_a", i),   32'(gnt_a),    32'(vecs[i].e_gnt_a));
      checkOutput($sformatf("v%0d gnt_b", i),   32'(gnt_b),    32'(vecs[i].e_gnt_b));
      checkOutput($sformatf("v%0d sel", i),     32'(sel),      32'(vecs[i].e_gnt_a));
      checkOutput($sformatf("v%0d y", i),       32'(y),        32'(vecs[i].e_y));
      checkOutput($sformatf("v%0d y_valid", i), 32'(y_valid),  32'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d cnt", i),     32'(xfer_cnt), 32'(vecs[i].e_cnt));
    end
`endif

    // Counter wrap: 256 back-to-back transfers from A return the count to 0
    begin
      logic [7:0] exp_cnt;
      doReset();
      @(negedge clk);
      applyStimulus(1'b1, 4'h1, 1'b0, 4'h0, 1'b1);
      exp_cnt = 8'd0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk);
        #1;
        checkOutput($sformatf("wrap cnt k%0d", k), 32'(xfer_cnt), 32'(exp_cnt));
        exp_cnt = exp_cnt + 8'd1;
      end
      @(negedge clk);
      #1;
      checkOutput("wrap final cnt", 32'(xfer_cnt), 32'd0);
    end

    // Reset pulse in the middle of a GNT_B transfer
    doReset();
    @(negedge clk);
    applyStimulus(1'b0, 4'h0, 1'b1, 4'hC, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("midrst pre gnt_b",   32'(gnt_b),   32'd1);
    checkOutput("midrst pre y_valid", 32'(y_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst gnt_b",   32'(gnt_b),    32'd0);
    checkOutput("midrst gnt_a",   32'(gnt_a),    32'd0);
    checkOutput("midrst sel",     32'(sel),      32'd0);
    checkOutput("midrst y",       32'(y),        32'd0);
    checkOutput("midrst y_valid", 32'(y_valid),  32'd0);
    checkOutput("midrst cnt",     32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'h7, 1'b1, 4'hC, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("postrst gnt_a", 32'(gnt_a),    32'd1);
    checkOutput("postrst gnt_b", 32'(gnt_b),    32'd0);
    checkOutput("postrst y",     32'(y),        32'h7);
    checkOutput("postrst cnt",   32'(xfer_cnt), 32'd0);

`ifdef MUX2_ARB_BURST_EN
    // Both requests held: ownership flips every four transfers
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 4'h3, 1'b1, 4'h5, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("burst k%0d gnt_a", k), 32'(gnt_a), 32'(((k / 4) % 2) == 0));
      checkOutput($sformatf("burst k%0d gnt_b", k), 32'(gnt_b), 32'(((k / 4) % 2) == 1));
      checkOutput($sformatf("burst k%0d cnt", k),   32'(xfer_cnt), 32'(k));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
